// File: rtl/and2_arbiter_pkg.sv
// Shared types and helpers for the and2 round-robin arbiter.
package and2_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Widest requester vector the round-robin helper can search.
   localparam int unsigned MaxReq  = 32;
   localparam int unsigned MaxIdxW = 5;

   // Round-robin pick: first set bit at or above ptr, wrapping modulo num_req.
   // Returns -1 when no bit in the lower num_req positions is set.
   function automatic int rr_pick(input logic [MaxReq-1:0] valid,
                                  input int                ptr,
                                  input int                num_req);
      int pick;
      int idx;
      pick = -1;
      for (int i = 0; i < MaxReq; i++) begin
         if (i < num_req) begin
            idx = ptr + i;
            if (idx >= num_req) begin
               idx = idx - num_req;
            end
            if (pick < 0 && valid[idx[MaxIdxW-1:0]]) begin
               pick = idx;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/and2_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection for the and2 arbiter.
module rr_arbiter
   import and2_arbiter_pkg::*;
#(
   parameter  int unsigned NumReq = 4,
   localparam int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] valid_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] grant_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              found_o
);

   logic [MaxReq-1:0] valid_ext;
   int                pick;

   // Search upward from ptr for the first active requester and encode it.
   always_comb begin
      valid_ext               = '0;
      valid_ext[NumReq-1:0]   = valid_i;
      pick                    = rr_pick(valid_ext, int'(ptr_i), int'(NumReq));
      grant_o                 = '0;
      idx_o                   = '0;
      found_o                 = 1'b0;
      if (pick >= 0) begin
         found_o        = 1'b1;
         idx_o          = IdxW'(pick);
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/and2_arbiter.sv
// Round-robin arbiter/sequencer sharing one and2 unit between NumReq clients.
module and2_arbiter
   import and2_arbiter_pkg::*;
#(
   parameter int unsigned Width   = 32,
   parameter int unsigned NumReq  = 4,
   parameter int unsigned Timeout = 15
) (
   input  logic                    clk,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       req_valid_i,
   output logic [NumReq-1:0]       req_ready_o,
   input  logic [NumReq*Width-1:0] req_in0_i,
   input  logic [NumReq*Width-1:0] req_in1_i,
   output logic [NumReq-1:0]       rsp_valid_o,
   input  logic [NumReq-1:0]       rsp_ready_i,
   output logic [Width-1:0]        rsp_data_o,
   output logic                    rsp_err_o,
   output logic                    unit_start_o,
   output logic [Width-1:0]        unit_in0_o,
   output logic [Width-1:0]        unit_in1_o,
   input  logic [Width-1:0]        unit_out_i,
   input  logic                    unit_ready_i,
   output logic                    busy_o
);

   localparam int unsigned IdxW = $clog2(NumReq);
   localparam int unsigned TmrW = $clog2(Timeout);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(Timeout - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

   arb_state_e        state_q, state_d;
   logic [IdxW-1:0]   ptr_q;
   logic [IdxW-1:0]   gnt_q;
   logic [TmrW-1:0]   tmr_q;
   logic [Width-1:0]  op0_q, op1_q;
   logic [Width-1:0]  rsp_data_q;
   logic              err_q;

   logic [NumReq-1:0] arb_grant;
   logic [IdxW-1:0]   arb_idx;
   logic              arb_found;
   logic [Width-1:0]  sel_in0, sel_in1;

   rr_arbiter #(
      .NumReq (NumReq)
   ) u_rr_arbiter (
      .valid_i (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .found_o (arb_found)
   );

   // Pick the operand slices belonging to the requester the arbiter selected.
   always_comb begin
      sel_in0 = '0;
      sel_in1 = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (arb_idx == IdxW'(k)) begin
            sel_in0 = req_in0_i[k*Width +: Width];
            sel_in1 = req_in1_i[k*Width +: Width];
         end
      end
   end

   // Next-state and handshake outputs; accepts are masked while reset is held
   // so every output reads zero during reset.
   always_comb begin
      state_d      = state_q;
      req_ready_o  = '0;
      rsp_valid_o  = '0;
      unit_start_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_found && rst_ni) begin
               req_ready_o = arb_grant;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            unit_start_o = 1'b1;
            state_d      = WAIT;
         end
         WAIT: begin
            if (unit_ready_i || (tmr_q == TmrLast)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid_o[gnt_q] = 1'b1;
            if (rsp_ready_i[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath: capture the accepted request, run the watchdog, latch the result.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         gnt_q      <= '0;
         tmr_q      <= '0;
         op0_q      <= '0;
         op1_q      <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  op0_q <= sel_in0;
                  op1_q <= sel_in1;
                  gnt_q <= arb_idx;
                  ptr_q <= (arb_idx == IdxLast) ? '0 : arb_idx + 1'b1;
               end
            end
            ISSUE: begin
               tmr_q <= '0;
            end
            WAIT: begin
               if (unit_ready_i) begin
                  rsp_data_q <= unit_out_i;
                  err_q      <= 1'b0;
               end else if (tmr_q == TmrLast) begin
                  rsp_data_q <= '0;
                  err_q      <= 1'b1;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_data_o = rsp_data_q;
   assign rsp_err_o  = err_q;
   assign unit_in0_o = op0_q;
   assign unit_in1_o = op1_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_and2_arbiter.sv
// Directed testbench for and2_arbiter with a simple one-cycle and2 model.
module tb_and2_arbiter;

   localparam int Width   = 32;
   localparam int NumReq  = 4;
   localparam int Timeout = 15;

   logic                    clk;
   logic                    rst_n;
   logic [NumReq-1:0]       req_valid_i;
   logic [NumReq-1:0]       req_ready_o;
   logic [NumReq*Width-1:0] req_in0_i;
   logic [NumReq*Width-1:0] req_in1_i;
   logic [NumReq-1:0]       rsp_valid_o;
   logic [NumReq-1:0]       rsp_ready_i;
   logic [Width-1:0]        rsp_data_o;
   logic                    rsp_err_o;
   logic                    unit_start_o;
   logic [Width-1:0]        unit_in0_o;
   logic [Width-1:0]        unit_in1_o;
   logic [Width-1:0]        unit_out_i;
   logic                    unit_ready_i;
   logic                    busy_o;

   logic unit_hold;
   int   total;
   int   bad;

   and2_arbiter #(
      .Width   (Width),
      .NumReq  (NumReq),
      .Timeout (Timeout)
   ) dut (
      .clk          (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_in0_i    (req_in0_i),
      .req_in1_i    (req_in1_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o),
      .unit_start_o (unit_start_o),
      .unit_in0_o   (unit_in0_o),
      .unit_in1_o   (unit_in1_o),
      .unit_out_i   (unit_out_i),
      .unit_ready_i (unit_ready_i),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // and2 unit stand-in: answers one cycle after start unless held off.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_ready_i <= 1'b0;
         unit_out_i   <= '0;
      end else begin
         unit_ready_i <= unit_start_o & ~unit_hold;
         unit_out_i   <= unit_in0_o & unit_in1_o;
      end
   end

   // Absolute backstop so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout got=running want=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
      req_in0_i[k*Width +: Width] = a;
      req_in1_i[k*Width +: Width] = b;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = '0;
      unit_hold   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_grant(input int max_cyc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (req_ready_o != '0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_rsp(input int max_cyc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (rsp_valid_o != '0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_valid_i = 4'b1111;
      rsp_ready_i = 4'b1111;
      unit_hold   = 1'b0;
      req_in0_i   = '1;
      req_in1_i   = '1;
      step();
      total++;
      if (req_ready_o !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_req_ready got=%b want=0000", req_ready_o);
      end
      total++;
      if (rsp_valid_o !== 4'b0000 || rsp_err_o !== 1'b0 || rsp_data_o !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_rsp got=%b/%b/%h want=0000/0/00000000", rsp_valid_o, rsp_err_o, rsp_data_o);
      end
      total++;
      if (unit_start_o !== 1'b0 || busy_o !== 1'b0 || unit_in0_o !== 32'h0 || unit_in1_o !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_unit got=%b/%b/%h/%h want=0/0/0/0", unit_start_o, busy_o, unit_in0_o, unit_in1_o);
      end
      req_valid_i = '0;
      rst_n       = 1'b1;
      step();
   endtask

   task automatic test_single();
      set_ops(0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      req_valid_i = 4'b0001;
      rsp_ready_i = 4'b1111;
      #1;
      total++;
      if (req_ready_o !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL single_accept got=%b want=0001", req_ready_o);
      end
      step();
      req_valid_i = '0;
      total++;
      if (unit_start_o !== 1'b1 || unit_in0_o !== 32'hF0F0_1234 || unit_in1_o !== 32'h0FF0_FFFF) begin
         bad++;
         $display("[TB] FAIL single_issue got=%b/%h/%h want=1/f0f01234/0ff0ffff", unit_start_o, unit_in0_o, unit_in1_o);
      end
      step();
      total++;
      if (unit_start_o !== 1'b0 || rsp_valid_o !== 4'b0000 || busy_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_wait got=%b/%b/%b want=0/0000/1", unit_start_o, rsp_valid_o, busy_o);
      end
      step();
      total++;
      if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 32'h00F0_1234 || rsp_err_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_rsp got=%b/%h/%b want=0001/00f01234/0", rsp_valid_o, rsp_data_o, rsp_err_o);
      end
      step();
      total++;
      if (rsp_valid_o !== 4'b0000 || busy_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_idle got=%b/%b want=0000/0", rsp_valid_o, busy_o);
      end
   endtask

   task automatic test_simultaneous();
      logic ok;
      do_reset();
      for (int k = 0; k < NumReq; k++) begin
         set_ops(k, 32'hFFFF_FFFF, 32'(k));
      end
      req_valid_i = 4'b1111;
      rsp_ready_i = 4'b1111;
      #1;
      for (int k = 0; k < NumReq; k++) begin
         wait_grant(10, ok);
         total++;
         if (!ok || req_ready_o !== 4'(1 << k)) begin
            bad++;
            $display("[TB] FAIL simul_grant%0d got=%b want=%b", k, req_ready_o, 4'(1 << k));
         end
         step();
         req_valid_i[k] = 1'b0;
         wait_rsp(10, ok);
         total++;
         if (!ok || rsp_valid_o !== 4'(1 << k) || rsp_data_o !== 32'(k)) begin
            bad++;
            $display("[TB] FAIL simul_rsp%0d got=%b/%h want=%b/%h", k, rsp_valid_o, rsp_data_o, 4'(1 << k), 32'(k));
         end
         step();
      end
   endtask

   task automatic test_fairness();
      logic       ok;
      logic [3:0] exp_g [4];
      logic [31:0] exp_d [4];
      exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      exp_d = '{32'h0000_5678, 32'h1234_0000, 32'h0000_5678, 32'h1234_0000};
      do_reset();
      set_ops(0, 32'h0000_FFFF, 32'h1234_5678);
      set_ops(2, 32'hFFFF_0000, 32'h1234_5678);
      req_valid_i = 4'b0101;
      rsp_ready_i = 4'b1111;
      #1;
      for (int i = 0; i < 4; i++) begin
         wait_grant(10, ok);
         total++;
         if (!ok || req_ready_o !== exp_g[i]) begin
            bad++;
            $display("[TB] FAIL fair_grant%0d got=%b want=%b", i, req_ready_o, exp_g[i]);
         end
         step();
         wait_rsp(10, ok);
         total++;
         if (!ok || rsp_valid_o !== exp_g[i] || rsp_data_o !== exp_d[i]) begin
            bad++;
            $display("[TB] FAIL fair_rsp%0d got=%b/%h want=%b/%h", i, rsp_valid_o, rsp_data_o, exp_g[i], exp_d[i]);
         end
         step();
      end
      req_valid_i = '0;
   endtask

   task automatic test_backpressure();
      logic ok;
      int   drift;
      do_reset();
      set_ops(0, 32'hAAAA_5555, 32'hFFFF_0000);
      set_ops(1, 32'h1234_5678, 32'h0000_FFFF);
      req_valid_i = 4'b0011;
      rsp_ready_i = 4'b1110;
      #1;
      total++;
      if (req_ready_o !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL bp_accept got=%b want=0001", req_ready_o);
      end
      step();
      req_valid_i = 4'b0010;
      wait_rsp(10, ok);
      drift = 0;
      for (int c = 0; c < 5; c++) begin
         if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 32'hAAAA_0000 || rsp_err_o !== 1'b0 || req_ready_o !== 4'b0000) begin
            drift++;
         end
         step();
      end
      total++;
      if (!ok || drift != 0) begin
         bad++;
         $display("[TB] FAIL bp_hold got=%0d bad cycles want=0", drift);
      end
      rsp_ready_i = 4'b1111;
      #1;
      total++;
      if (rsp_valid_o !== 4'b0001 || req_ready_o !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL bp_handshake got=%b/%b want=0001/0000", rsp_valid_o, req_ready_o);
      end
      step();
      total++;
      if (req_ready_o !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL bp_next_accept got=%b want=0010", req_ready_o);
      end
      step();
      req_valid_i = '0;
      wait_rsp(10, ok);
      total++;
      if (!ok || rsp_valid_o !== 4'b0010 || rsp_data_o !== 32'h0000_5678) begin
         bad++;
         $display("[TB] FAIL bp_next_rsp got=%b/%h want=0010/00005678", rsp_valid_o, rsp_data_o);
      end
      step();
   endtask

   task automatic test_watchdog();
      logic ok;
      int   early;
      do_reset();
      unit_hold = 1'b1;
      set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      req_valid_i = 4'b0010;
      rsp_ready_i = 4'b1111;
      #1;
      wait_grant(5, ok);
      total++;
      if (!ok || req_ready_o !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL wd_accept got=%b want=0010", req_ready_o);
      end
      early = 0;
      for (int c = 1; c <= Timeout + 1; c++) begin
         step();
         req_valid_i = '0;
         if (rsp_valid_o !== 4'b0000 || busy_o !== 1'b1) begin
            early++;
         end
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("[TB] FAIL wd_early got=%0d bad cycles want=0", early);
      end
      step();
      total++;
      if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0) begin
         bad++;
         $display("[TB] FAIL wd_rsp got=%b/%b/%h want=0010/1/00000000", rsp_valid_o, rsp_err_o, rsp_data_o);
      end
      unit_hold = 1'b0;
      step();
      set_ops(2, 32'h0F0F_0F0F, 32'hFFFF_0000);
      req_valid_i = 4'b0100;
      #1;
      total++;
      if (req_ready_o !== 4'b0100) begin
         bad++;
         $display("[TB] FAIL wd_next_accept got=%b want=0100", req_ready_o);
      end
      step();
      req_valid_i = '0;
      step();
      step();
      total++;
      if (rsp_valid_o !== 4'b0100 || rsp_err_o !== 1'b0 || rsp_data_o !== 32'h0F0F_0000) begin
         bad++;
         $display("[TB] FAIL wd_next_rsp got=%b/%b/%h want=0100/0/0f0f0000", rsp_valid_o, rsp_err_o, rsp_data_o);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic ok;
      do_reset();
      unit_hold = 1'b1;
      set_ops(1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      req_valid_i = 4'b0010;
      rsp_ready_i = 4'b1111;
      #1;
      wait_grant(5, ok);
      total++;
      if (!ok || req_ready_o !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL rmid_accept got=%b want=0010", req_ready_o);
      end
      step();
      total++;
      if (unit_start_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rmid_issue got=%b want=1", unit_start_o);
      end
      step();
      rst_n       = 1'b0;
      unit_hold   = 1'b0;
      req_valid_i = 4'b1000;
      set_ops(3, 32'hCAFE_0000, 32'hFFFF_FFFF);
      #1;
      total++;
      if ({req_ready_o, rsp_valid_o, unit_start_o, busy_o, rsp_err_o, unit_in0_o, rsp_data_o} !== '0) begin
         bad++;
         $display("[TB] FAIL rmid_in_reset got=%b/%b/%b/%b/%h want=all zero", req_ready_o, rsp_valid_o, unit_start_o, busy_o, unit_in0_o);
      end
      step();
      rst_n = 1'b1;
      #1;
      total++;
      if (req_ready_o !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL rmid_only_req3 got=%b want=1000", req_ready_o);
      end
      step();
      req_valid_i = '0;
      wait_rsp(10, ok);
      total++;
      if (!ok || rsp_valid_o !== 4'b1000 || rsp_data_o !== 32'hCAFE_0000) begin
         bad++;
         $display("[TB] FAIL rmid_req3_rsp got=%b/%h want=1000/cafe0000", rsp_valid_o, rsp_data_o);
      end
      step();
      unit_hold   = 1'b1;
      req_valid_i = 4'b0010;
      #1;
      wait_grant(5, ok);
      step();
      req_valid_i = '0;
      step();
      rst_n       = 1'b0;
      unit_hold   = 1'b0;
      set_ops(0, 32'h1111_1111, 32'h0101_0101);
      req_valid_i = 4'b1001;
      step();
      rst_n = 1'b1;
      #1;
      total++;
      if (!ok || req_ready_o !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rmid_ptr_cleared got=%b want=0001", req_ready_o);
      end
      step();
      req_valid_i = '0;
      wait_rsp(10, ok);
      total++;
      if (!ok || rsp_valid_o !== 4'b0001 || rsp_data_o !== 32'h0101_0101) begin
         bad++;
         $display("[TB] FAIL rmid_req0_rsp got=%b/%h want=0001/01010101", rsp_valid_o, rsp_data_o);
      end
      step();
   endtask

   // Run every scenario in order, then report.
   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = '0;
      req_in0_i   = '0;
      req_in1_i   = '0;
      unit_hold   = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/and2_arbiter.md
# and2_arbiter

Round-robin arbiter and sequencer that shares one `and2` bitwise-AND unit between `NumReq` requesters. It accepts one operand pair at a time over per-requester valid/ready channels and drives the unit's start/operand inputs. It then captures the unit's result and returns it to the winning requester over a response channel, with a watchdog that flags an error if the unit never signals ready. It sits between client masters and a single `and2` instance in the system block.

## Interface
- `Width`, 32: operand/result width; must match the attached `and2` instance.
- `NumReq`, 4: number of requesters, ≥2.
- `Timeout`, 15: cycles spent in WAIT before the watchdog fires, ≥2.
- `clk`  in  1  clock; one clock for the whole block.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester accept, one-hot or zero.
- `req_in0_i`  in  NumReq*Width  operand A; requester k uses slice [k*Width +: Width].
- `req_in1_i`  in  NumReq*Width  operand B; same slicing as `req_in0_i`.
- `rsp_valid_o`  out  NumReq  per-requester response valid, one-hot or zero.
- `rsp_ready_i`  in  NumReq  per-requester response accept.
- `rsp_data_o`  out  Width  result; shared by all requesters.
- `rsp_err_o`  out  1  watchdog error flag; valid with `rsp_valid_o`.
- `unit_start_o`  out  1  drives `and2.start_i`.
- `unit_in0_o`, `unit_in1_o`  out  Width  drive `and2.in0_i`/`in1_i`.
- `unit_out_i`  in  Width  from `and2.out_o`.
- `unit_ready_i`  in  1  from `and2.ready_o`.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` bit is set, grant g is chosen round-robin: the first set bit searching upward from `ptr` and wrapping modulo NumReq.
  - `req_ready_o[g]` is driven combinationally high that cycle. The operands, g and the grant are registered.
  - `ptr <= (g+1) mod NumReq`. Next state is ISSUE.
- **ISSUE**
  - `unit_start_o` = 1 for exactly this cycle. Next state is WAIT and `tmr <= 0`.
- **WAIT**
  - If `unit_ready_i` = 1: `rsp_data <= unit_out_i`, `err <= 0`, next state is RESP.
  - Otherwise, if `tmr == Timeout-1`: `rsp_data <= 0`, `err <= 1`, next state is RESP.
  - Otherwise: `tmr++`.
- **RESP**
  - `rsp_valid_o[g]` = 1, and `rsp_data_o`/`rsp_err_o` are held stable until `rsp_ready_i[g]` = 1. Then next state is IDLE.
  - `rsp_ready_i` bits for other requesters are ignored.
- `unit_in0_o`/`unit_in1_o` come from the operand registers and stay stable from ISSUE through WAIT.
- `unit_ready_i` is ignored in every state except WAIT.
- No new request is accepted outside IDLE: `req_ready_o` is all-zero there.
- Index width is `$clog2(NumReq)`. Timer width is `$clog2(Timeout)`; the timer never wraps.

## Timing
- **Reset values:** every output 0; state IDLE, `ptr` 0, `tmr` 0, operand/data registers 0.
- **Reset mid-operation:** the transaction is dropped and no response is issued. `unit_start_o` drops immediately (asynchronous).
- **Nominal latency:** with request accepted in cycle t, ISSUE is t+1. The unit's ready arrives at t+2, so `rsp_valid_o` rises at t+3.
- **Back-to-back:** with `rsp_ready_i` tied high, the next accept happens no earlier than t+4, giving a peak throughput of 1 op per 4 cycles.
- **Watchdog:** with no unit ready, WAIT lasts exactly Timeout cycles and `rsp_valid_o` rises at t+2+Timeout.
- **Simultaneous requests:** exactly one grant per IDLE cycle, decided by `ptr`. The requester granted last has lowest priority next time.
- **Request withdrawal:** a requester may drop `req_valid_i` before being granted, and the block must not grant it.

## Structure
- Package `and2_arbiter_pkg` holds:
  - the `arb_state_e` enum (IDLE, ISSUE, WAIT, RESP);
  - a parameterised helper function for the round-robin pick.
- One natural sub-module, `rr_arbiter`:
  - combinational; inputs are the valid vector and `ptr`; outputs are the one-hot grant, the grant index and a `found` flag.
  - It is instantiated once.
- The `and2` instance is external and connected in the system block.

## Test plan
- **Single request.** Stimulus: req0 with in0=0xF0F0_1234, in1=0x0FF0_FFFF, accepted at t. Response: `unit_start_o` high at t+1 only; at t+3, `rsp_valid_o`=4'b0001, data=0x00F0_1234, err=0.
- **Simultaneous requests from reset.** Stimulus: all four requesters valid from reset, each with in0=0xFFFF_FFFF and in1=k. Response: grants in order 0,1,2,3; each response carries data=k to requester k only.
- **Fairness.** Stimulus: req0 and req2 held valid continuously. Response: grants alternate 0,2,0,2; req1 and req3 never granted.
- **Response backpressure.** Stimulus: `rsp_ready_i` low for 5 cycles in RESP. Response: `rsp_valid_o`, data and err held stable; `req_ready_o`=0 throughout; a queued req1 is accepted the cycle after the handshake.
- **Watchdog.** Stimulus: `unit_ready_i` tied 0, Timeout=15. Response: `rsp_valid_o` at t+17 with err=1, data=0; the next request proceeds normally.
- **Reset mid-WAIT.** Stimulus: `rst_ni` pulsed low during WAIT. Response: all outputs 0 during reset, no response issued. After release, a pending req3 is granted first if it is the only one valid, otherwise req0 wins (ptr=0).
